cpu16_core: RTL and testbench
=============================

# cpu16_core

16-bit single-issue processor core for the small board-level system. It fetches 16-bit instructions from a synchronous instruction memory and executes most of them in one cycle. It accesses a 16-bit word-addressed synchronous data memory, provides simple IN/OUT port I/O, and raises a halt flag. Companion blocks `imem` and `dmem` are word-addressed memories with a registered read: data for an address presented in cycle N is valid in cycle N+1.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `nextpc`  out  16  instruction address for the next cycle; drives the imem read address.
- `inst`  in  16  instruction word, imem[nextpc of the previous cycle].
- `main_mem_read_adr`  out  16  dmem read address; combinational.
- `main_mem_dat`  in  16  dmem[main_mem_read_adr of the previous cycle].
- `main_mem_write`  out  1  dmem write enable; combinational.
- `main_mem_write_adr`  out  16  dmem write address.
- `main_mem_write_dat`  out  16  dmem write data.
- `in_dat`  in  16  input port value, sampled by IN.
- `out_en`  out  1  one-cycle strobe qualifying `out_dat`.
- `out_dat`  out  16  output port value.
- `is_halt`  out  1  sticky halt flag.

## Operation
- State: `pc[15:0]`; r0–r7 (16 bit, all general purpose); flags S, Z, C, V; `ld_wait`; `halt`. Reset clears all of them to 0.
- Fields: `Rs/Ra = inst[13:11]`; `Rd/Rb = inst[10:8]`.
- `inst[15:14]=11`, ALU/IO group; `op = inst[7:4]`; `d = inst[3:0]`.
  - 0 ADD: Rd = Rd+Rs. 1 SUB: Rd = Rd−Rs. 2 AND. 3 OR. 4 XOR.
  - 5 CMP: flags of Rd−Rs only; no register write.
  - 6 MOV: Rd = Rs.
  - 8 SLL: Rd << d. 9 SLR: rotate left by d. 10 SRL: logical right by d. 11 SRA: arithmetic right by d.
  - 12 IN: Rd = in_dat.
  - 13 OUT: out_dat = Rs, out_en = 1.
  - 15 HLT. Ops 7 and 14 are NOPs.
- Flags, updated by ops 0–11:
  - S = result[15]; Z = (result == 0).
  - ADD/SUB/CMP: C = carry out (borrow for SUB/CMP); V = signed overflow.
  - Other flag-setting ops: C = V = 0.
  - All other instructions leave the flags unchanged.
- `inst[15:14]=00` LD: Ra = dmem[Rb + sext(inst[7:0])].
- `inst[15:14]=01` ST: dmem[Rb + sext(inst[7:0])] = Ra.
- `inst[15:14]=10`; `op2 = inst[13:11]`:
  - 000 LI: Rb = sext(inst[7:0]).
  - 100 B: pc = pc+1+sext(inst[7:0]).
  - 111 conditional branch to the same target; `inst[10:8]` selects the condition: 000 BE (Z), 001 BLT (S^V), 010 BLE (Z|(S^V)), 011 BNE (!Z).
  - All other encodings are NOPs.
- All arithmetic is 16-bit modulo 2^16; pc wraps from 0xFFFF to 0.
- `nextpc`, combinational:
  - 0 while `reset`.
  - `pc` while `halt`, or in the first cycle of an LD.
  - Branch target when a branch is taken; otherwise pc+1.
  - `pc <= nextpc` every cycle.
- LD is a two-cycle FSM, states EXEC and LDWAIT:
  - EXEC: drive `main_mem_read_adr`, set `ld_wait <= 1`, refetch the same pc.
  - LDWAIT: write `main_mem_dat` to Ra, clear `ld_wait`, nextpc = pc+1.
- ST is single cycle: `main_mem_write = 1` with address and data driven combinationally; dmem commits at the edge.
- HLT sets `halt` at the edge; the core then freezes, with no register, memory or port activity. Only reset clears `halt`.
- `is_halt = halt`.
- `out_en` and `main_mem_write` are 0 during reset and while halted.
- imem/dmem:
  - Registered read.
  - dmem read of an address written in the same cycle returns the old data.
  - Contents are undefined unless preloaded.

## Timing
- Reset values: nextpc = 0; all strobes = 0; is_halt = 0; out_dat = 0; the remaining outputs are don't-care.
- First instruction, imem[0], executes in the first cycle after reset deasserts.
- Latency: 1 cycle for all instructions except LD (2 cycles). Taken branches cost no penalty.
- `out_en` is high for exactly the cycle OUT executes.
- Reset asserted mid-LD or after halt aborts the operation; the core restarts at pc 0 with registers cleared.

## Test plan
- LI r1,5; LI r2,3; ADD r1,r2; OUT r1 -> out_en pulses once with out_dat = 8; Z = 0, C = 0.
- LI r1,−1; LI r2,1; ADD r1,r2 -> r1 = 0, Z = 1, C = 1; then BE +1 skips one instruction, verified by an OUT trace.
- LI r3,0x10; LI r4,0x55; ST r4,2(r3); LD r5,2(r3); OUT r5 -> main_mem_write at adr 0x12, dat 0x0055; out_dat = 0x0055; LD occupies 2 cycles.
- Countdown loop using SUB/CMP/BNE with OUT each iteration -> out_dat sequence 3, 2, 1, then exits; BLT/BLE checked with negative operands.
- IN r1 with in_dat = 0x1234, then SRA r1,4 and OUT -> out_dat = 0x0123; SLR of 0x8001 by 1 gives 0x0003.
- HLT -> is_halt = 1 from the next cycle and nextpc frozen; assert reset for 3 cycles -> is_halt = 0, nextpc = 0, and execution restarts at address 0.

Source files
------------

// File: rtl/cpu16_core.sv
// cpu16_core: 16-bit single-issue core with registered-read imem/dmem, port I/O and sticky halt.
// Everything executes in one cycle except LD, which waits one extra cycle for dmem read data.
module cpu16_core (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] nextpc,
  input  logic [15:0] inst,
  output logic [15:0] main_mem_read_adr,
  input  logic [15:0] main_mem_dat,
  output logic        main_mem_write,
  output logic [15:0] main_mem_write_adr,
  output logic [15:0] main_mem_write_dat,
  input  logic [15:0] in_dat,
  output logic        out_en,
  output logic [15:0] out_dat,
  output logic        is_halt
);

  typedef enum logic {EXEC, LDWAIT} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q;
  logic [15:0] regs_q [8];
  logic        s_q, z_q, c_q, v_q;
  logic        halt_q, halt_d;

  logic [2:0]  rs, rd;
  logic [3:0]  op, sh;
  logic [15:0] imm, a, b, pc_inc, br_tgt;
  logic [15:0] res;
  logic [16:0] sum17;
  logic [31:0] rot;
  logic        c_n, v_n, take;
  logic        rf_we, flag_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;

  assign rs     = inst[13:11];
  assign rd     = inst[10:8];
  assign op     = inst[7:4];
  assign sh     = inst[3:0];
  assign imm    = {{8{inst[7]}}, inst[7:0]};
  assign a      = regs_q[rd];
  assign b      = regs_q[rs];
  assign pc_inc = pc_q + 16'd1;
  assign br_tgt = pc_inc + imm;

  assign main_mem_read_adr  = a + imm;
  assign main_mem_write_adr = a + imm;
  assign main_mem_write_dat = b;
  assign out_dat            = out_en ? b : 16'h0000;
  assign is_halt            = halt_q;

  always_comb begin
    res   = 16'h0000;
    sum17 = 17'h0;
    rot   = 32'h0;
    c_n   = 1'b0;
    v_n   = 1'b0;
    case (op)
      4'd0: begin
        sum17 = {1'b0, a} + {1'b0, b};
        res   = sum17[15:0];
        c_n   = sum17[16];
        v_n   = (a[15] == b[15]) && (res[15] != a[15]);
      end
      4'd1, 4'd5: begin
        sum17 = {1'b0, a} - {1'b0, b};
        res   = sum17[15:0];
        c_n   = sum17[16];
        v_n   = (a[15] != b[15]) && (res[15] != a[15]);
      end
      4'd2:  res = a & b;
      4'd3:  res = a | b;
      4'd4:  res = a ^ b;
      4'd6:  res = b;
      4'd8:  res = a << sh;
      4'd9: begin
        rot = {a, a} << sh;
        res = rot[31:16];
      end
      4'd10: res = a >> sh;
      4'd11: res = $signed(a) >>> sh;
      default: res = 16'h0000;
    endcase
  end

  always_comb begin
    case (rd)
      3'd0:    take = z_q;
      3'd1:    take = s_q ^ v_q;
      3'd2:    take = z_q | (s_q ^ v_q);
      3'd3:    take = ~z_q;
      default: take = 1'b0;
    endcase
  end

  // LD refetches its own pc in EXEC so the same instruction is present in LDWAIT.
  always_comb begin
    state_d        = state_q;
    halt_d         = halt_q;
    nextpc         = pc_inc;
    rf_we          = 1'b0;
    rf_waddr       = rd;
    rf_wdata       = res;
    flag_we        = 1'b0;
    out_en         = 1'b0;
    main_mem_write = 1'b0;
    if (reset) begin
      nextpc = 16'h0000;
    end else if (halt_q) begin
      nextpc = pc_q;
    end else begin
      case (state_q)
        LDWAIT: begin
          rf_we    = 1'b1;
          rf_waddr = rs;
          rf_wdata = main_mem_dat;
          state_d  = EXEC;
        end
        EXEC: begin
          case (inst[15:14])
            2'b00: begin
              state_d = LDWAIT;
              nextpc  = pc_q;
            end
            2'b01: main_mem_write = 1'b1;
            2'b10: begin
              case (inst[13:11])
                3'b000: begin
                  rf_we    = 1'b1;
                  rf_wdata = imm;
                end
                3'b100: nextpc = br_tgt;
                3'b111: if (take) nextpc = br_tgt;
                default: ;
              endcase
            end
            default: begin
              case (op)
                4'd5: flag_we = 1'b1;
                4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11: begin
                  flag_we = 1'b1;
                  rf_we   = 1'b1;
                end
                4'd12: begin
                  rf_we    = 1'b1;
                  rf_wdata = in_dat;
                end
                4'd13: out_en = 1'b1;
                4'd15: halt_d = 1'b1;
                default: ;
              endcase
            end
          endcase
        end
        default: state_d = EXEC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EXEC;
      pc_q    <= 16'h0000;
      halt_q  <= 1'b0;
      s_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= nextpc;
      halt_q  <= halt_d;
      if (rf_we) regs_q[rf_waddr] <= rf_wdata;
      if (flag_we) begin
        s_q <= res[15];
        z_q <= (res == 16'h0000);
        c_q <= c_n;
        v_q <= v_n;
      end
    end
  end

endmodule

// File: tb/tb_cpu16_core.sv
// Self-checking bench for cpu16_core: small programs with a bench-side imem/dmem model,
// expected OUT values queued per program and matched against the observed OUT stream.
module tb_cpu16_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] nextpc;
  logic [15:0] inst = 16'h0000;
  logic [15:0] main_mem_read_adr;
  logic [15:0] main_mem_dat = 16'h0000;
  logic        main_mem_write;
  logic [15:0] main_mem_write_adr;
  logic [15:0] main_mem_write_dat;
  logic [15:0] in_dat = 16'h0000;
  logic        out_en;
  logic [15:0] out_dat;
  logic        is_halt;

  cpu16_core dut (
    .clk(clk), .reset(reset), .nextpc(nextpc), .inst(inst),
    .main_mem_read_adr(main_mem_read_adr), .main_mem_dat(main_mem_dat),
    .main_mem_write(main_mem_write), .main_mem_write_adr(main_mem_write_adr),
    .main_mem_write_dat(main_mem_write_dat), .in_dat(in_dat),
    .out_en(out_en), .out_dat(out_dat), .is_halt(is_halt)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] HLT = 16'hC0F0;

  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  logic [15:0] prog [$];
  logic [15:0] exp_q [$];
  logic [15:0] obs_q [$];
  int          obs_rd = 0;
  int          wr_count = 0;
  logic [15:0] wr_adr = 16'h0000;
  logic [15:0] wr_dat = 16'h0000;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) begin
    inst         <= imem[nextpc[7:0]];
    main_mem_dat <= dmem[main_mem_read_adr[7:0]];
    if (main_mem_write === 1'b1) dmem[main_mem_write_adr[7:0]] <= main_mem_write_dat;
  end

  always @(negedge clk) begin
    if (out_en === 1'b1) obs_q.push_back(out_dat);
    if (main_mem_write === 1'b1) begin
      wr_count = wr_count + 1;
      wr_adr   = main_mem_write_adr;
      wr_dat   = main_mem_write_dat;
    end
  end

  function automatic logic [15:0] e_alu(input logic [3:0] op, input logic [2:0] rs,
                                        input logic [2:0] rd, input logic [3:0] d);
    return {2'b11, rs, rd, op, d};
  endfunction
  function automatic logic [15:0] e_out(input logic [2:0] r);
    return {2'b11, r, 3'd0, 4'd13, 4'd0};
  endfunction
  function automatic logic [15:0] e_li(input logic [2:0] rb, input logic [7:0] imm);
    return {2'b10, 3'b000, rb, imm};
  endfunction
  function automatic logic [15:0] e_ld(input logic [2:0] ra, input logic [2:0] rb, input logic [7:0] imm);
    return {2'b00, ra, rb, imm};
  endfunction
  function automatic logic [15:0] e_st(input logic [2:0] ra, input logic [2:0] rb, input logic [7:0] imm);
    return {2'b01, ra, rb, imm};
  endfunction
  function automatic logic [15:0] e_bcc(input logic [2:0] cond, input logic [7:0] imm);
    return {2'b10, 3'b111, cond, imm};
  endfunction
  function automatic logic [15:0] e_b(input logic [7:0] imm);
    return {2'b10, 3'b100, 3'b000, imm};
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 256; i++) imem[i] = (i < prog.size()) ? prog[i] : HLT;
  endtask

  task automatic run_to_halt(input int budget, output int cycles);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    cycles = 0;
    while (is_halt !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic next_pair(output logic [15:0] e, output logic [15:0] o, output bit have);
    e    = exp_q.pop_front();
    have = (obs_rd < obs_q.size());
    o    = have ? obs_q[obs_rd] : 16'hxxxx;
    obs_rd++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks += 5;
    if (nextpc !== 16'h0000) begin failures++; $display("FAIL reset_nextpc got=%h exp=0000", nextpc); end
    if (out_en !== 1'b0) begin failures++; $display("FAIL reset_out_en got=%b exp=0", out_en); end
    if (main_mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write got=%b exp=0", main_mem_write); end
    if (is_halt !== 1'b0) begin failures++; $display("FAIL reset_is_halt got=%b exp=0", is_halt); end
    if (out_dat !== 16'h0000) begin failures++; $display("FAIL reset_out_dat got=%h exp=0000", out_dat); end
  endtask

  task automatic test_add_out();
    int cyc; logic [15:0] e, o; bit have;
    prog = '{e_li(1, 8'd5), e_li(2, 8'd3), e_alu(4'd0, 3'd2, 3'd1, 4'd0), e_out(1), HLT};
    load_prog();
    exp_q.push_back(16'h0008);
    run_to_halt(50, cyc);
    checks += 4;
    if (is_halt !== 1'b1) begin failures++; $display("FAIL add_halt got=%b exp=1", is_halt); end
    if (cyc != 5) begin failures++; $display("FAIL add_cycles got=%0d exp=5", cyc); end
    if (dut.z_q !== 1'b0) begin failures++; $display("FAIL add_z got=%b exp=0", dut.z_q); end
    if (dut.c_q !== 1'b0) begin failures++; $display("FAIL add_c got=%b exp=0", dut.c_q); end
    while (exp_q.size() > 0) begin
      next_pair(e, o, have);
      checks++;
      if (!have || o !== e) begin failures++; $display("FAIL add_out got=%h exp=%h", o, e); end
    end
    checks++;
    if (obs_q.size() != obs_rd) begin failures++; $display("FAIL add_extra_out got=%0d exp=%0d", obs_q.size(), obs_rd); end
    obs_rd = obs_q.size();
  endtask

  task automatic test_carry_branch();
    int cyc; logic [15:0] e, o; bit have;
    prog = '{e_li(1, 8'hFF), e_li(2, 8'd1), e_alu(4'd0, 3'd2, 3'd1, 4'd0), e_bcc(3'd0, 8'd1),
             e_out(2), e_out(1), e_b(8'd1), e_out(1), e_out(2), HLT};
    load_prog();
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    run_to_halt(50, cyc);
    checks += 4;
    if (is_halt !== 1'b1) begin failures++; $display("FAIL carry_halt got=%b exp=1", is_halt); end
    if (dut.z_q !== 1'b1) begin failures++; $display("FAIL carry_z got=%b exp=1", dut.z_q); end
    if (dut.c_q !== 1'b1) begin failures++; $display("FAIL carry_c got=%b exp=1", dut.c_q); end
    if (dut.v_q !== 1'b0) begin failures++; $display("FAIL carry_v got=%b exp=0", dut.v_q); end
    while (exp_q.size() > 0) begin
      next_pair(e, o, have);
      checks++;
      if (!have || o !== e) begin failures++; $display("FAIL carry_out got=%h exp=%h", o, e); end
    end
    checks++;
    if (obs_q.size() != obs_rd) begin failures++; $display("FAIL carry_extra_out got=%0d exp=%0d", obs_q.size(), obs_rd); end
    obs_rd = obs_q.size();
  endtask

  task automatic test_ld_st();
    int cyc, wr0; logic [15:0] e, o; bit have;
    prog = '{e_li(3, 8'h10), e_li(4, 8'h55), e_st(4, 3, 8'd2), e_ld(5, 3, 8'd2), e_out(5), HLT};
    load_prog();
    dmem[8'h12] = 16'hDEAD;
    exp_q.push_back(16'h0055);
    wr0 = wr_count;
    run_to_halt(50, cyc);
    checks += 5;
    if (is_halt !== 1'b1) begin failures++; $display("FAIL ldst_halt got=%b exp=1", is_halt); end
    if (cyc != 7) begin failures++; $display("FAIL ldst_cycles got=%0d exp=7", cyc); end
    if (wr_count - wr0 != 1) begin failures++; $display("FAIL ldst_wr_count got=%0d exp=1", wr_count - wr0); end
    if (wr_adr !== 16'h0012) begin failures++; $display("FAIL ldst_wr_adr got=%h exp=0012", wr_adr); end
    if (wr_dat !== 16'h0055) begin failures++; $display("FAIL ldst_wr_dat got=%h exp=0055", wr_dat); end
    while (exp_q.size() > 0) begin
      next_pair(e, o, have);
      checks++;
      if (!have || o !== e) begin failures++; $display("FAIL ldst_out got=%h exp=%h", o, e); end
    end
    checks++;
    if (obs_q.size() != obs_rd) begin failures++; $display("FAIL ldst_extra_out got=%0d exp=%0d", obs_q.size(), obs_rd); end
    obs_rd = obs_q.size();
  endtask

  task automatic test_loop_branches();
    int cyc; logic [15:0] e, o; bit have;
    logic [15:0] exp_vals [7] = '{16'h0003, 16'h0002, 16'h0001, 16'hFFFB, 16'hFFFE, 16'h0000, 16'h8000};
    prog = '{e_li(1, 8'd3), e_li(2, 8'd1), e_li(3, 8'd0), e_out(1),
             e_alu(4'd1, 3'd2, 3'd1, 4'd0), e_alu(4'd5, 3'd3, 3'd1, 4'd0), e_bcc(3'd3, 8'hFC),
             e_li(4, 8'hFB), e_li(5, 8'hFE), e_alu(4'd5, 3'd5, 3'd4, 4'd0), e_bcc(3'd1, 8'd1),
             e_out(3), e_out(4), e_alu(4'd5, 3'd4, 3'd5, 4'd0), e_bcc(3'd2, 8'd1), e_out(5),
             e_alu(4'd5, 3'd4, 3'd4, 4'd0), e_bcc(3'd2, 8'd1), e_out(2), e_out(1),
             e_li(6, 8'd1), e_alu(4'd8, 3'd0, 3'd6, 4'd15), e_alu(4'd5, 3'd2, 3'd6, 4'd0),
             e_bcc(3'd1, 8'd1), e_out(3), e_out(6), HLT};
    load_prog();
    foreach (exp_vals[i]) exp_q.push_back(exp_vals[i]);
    run_to_halt(200, cyc);
    checks++;
    if (is_halt !== 1'b1) begin failures++; $display("FAIL loop_halt got=%b exp=1", is_halt); end
    while (exp_q.size() > 0) begin
      next_pair(e, o, have);
      checks++;
      if (!have || o !== e) begin failures++; $display("FAIL loop_out got=%h exp=%h", o, e); end
    end
    checks++;
    if (obs_q.size() != obs_rd) begin failures++; $display("FAIL loop_extra_out got=%0d exp=%0d", obs_q.size(), obs_rd); end
    obs_rd = obs_q.size();
  endtask

  task automatic test_in_shift();
    int cyc; logic [15:0] e, o; bit have;
    logic [15:0] exp_vals [5] = '{16'h0123, 16'h0003, 16'hFFF8, 16'h012C, 16'h0120};
    prog = '{e_alu(4'd12, 3'd0, 3'd1, 4'd0), e_alu(4'd11, 3'd0, 3'd1, 4'd4), e_out(1),
             e_li(2, 8'd1), e_alu(4'd8, 3'd0, 3'd2, 4'd15), e_li(3, 8'd1),
             e_alu(4'd3, 3'd3, 3'd2, 4'd0), e_alu(4'd9, 3'd0, 3'd2, 4'd1), e_out(2),
             e_li(4, 8'h80), e_alu(4'd11, 3'd0, 3'd4, 4'd4), e_out(4),
             e_li(7, 8'hFF), e_alu(4'd10, 3'd0, 3'd7, 4'd12), e_alu(4'd4, 3'd1, 3'd7, 4'd0), e_out(7),
             e_alu(4'd6, 3'd4, 3'd6, 4'd0), e_alu(4'd2, 3'd1, 3'd6, 4'd0), e_out(6), HLT};
    load_prog();
    in_dat = 16'h1234;
    foreach (exp_vals[i]) exp_q.push_back(exp_vals[i]);
    run_to_halt(100, cyc);
    checks++;
    if (is_halt !== 1'b1) begin failures++; $display("FAIL shift_halt got=%b exp=1", is_halt); end
    while (exp_q.size() > 0) begin
      next_pair(e, o, have);
      checks++;
      if (!have || o !== e) begin failures++; $display("FAIL shift_out got=%h exp=%h", o, e); end
    end
    checks++;
    if (obs_q.size() != obs_rd) begin failures++; $display("FAIL shift_extra_out got=%0d exp=%0d", obs_q.size(), obs_rd); end
    obs_rd = obs_q.size();
  endtask

  task automatic test_halt_reset();
    int cyc, wr0; logic [15:0] e, o; bit have;
    prog = '{e_out(2), e_li(2, 8'd9), e_out(2), HLT};
    load_prog();
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0009);
    wr0 = wr_count;
    run_to_halt(50, cyc);
    checks++;
    if (is_halt !== 1'b1) begin failures++; $display("FAIL halt_set got=%b exp=1", is_halt); end
    repeat (4) begin
      @(negedge clk);
      checks += 2;
      if (nextpc !== 16'h0004) begin failures++; $display("FAIL halt_nextpc got=%h exp=0004", nextpc); end
      if (is_halt !== 1'b1) begin failures++; $display("FAIL halt_sticky got=%b exp=1", is_halt); end
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks += 2;
    if (is_halt !== 1'b0) begin failures++; $display("FAIL halt_reset_flag got=%b exp=0", is_halt); end
    if (nextpc !== 16'h0000) begin failures++; $display("FAIL halt_reset_nextpc got=%h exp=0000", nextpc); end
    reset = 1'b0;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0009);
    cyc = 0;
    while (is_halt !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checks += 3;
    if (is_halt !== 1'b1) begin failures++; $display("FAIL halt_restart got=%b exp=1", is_halt); end
    if (cyc != 4) begin failures++; $display("FAIL halt_restart_cycles got=%0d exp=4", cyc); end
    if (wr_count != wr0) begin failures++; $display("FAIL halt_no_write got=%0d exp=%0d", wr_count, wr0); end
    while (exp_q.size() > 0) begin
      next_pair(e, o, have);
      checks++;
      if (!have || o !== e) begin failures++; $display("FAIL halt_out got=%h exp=%h", o, e); end
    end
    checks++;
    if (obs_q.size() != obs_rd) begin failures++; $display("FAIL halt_extra_out got=%0d exp=%0d", obs_q.size(), obs_rd); end
    obs_rd = obs_q.size();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      imem[i] = HLT;
      dmem[i] = 16'h0000;
    end
    test_reset();
    test_add_out();
    test_carry_branch();
    test_ld_st();
    test_loop_branches();
    test_in_shift();
    test_halt_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
